port_pkt_buffer: RTL and testbench



---
 rtl/port_pkt_buffer.sv | 190 +++++++++++++++++++
 tb/tb_port_pkt_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_pkt_buffer.sv
// port_pkt_buffer: store-and-forward packet buffer behind one output port.
// Beats are written into a circular buffer. Only whole, well-formed packets
// are exposed to the valid/ready consumer. Over-length, overflowing or
// protocol-broken packets are rewound and reported with a one-cycle drop.
module port_pkt_buffer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 32,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [AW:0]       pkt_count,
  output logic              drop,
  output logic              full
);

  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT + 1);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

  logic [DATA_W:0] mem [DEPTH];

  wr_state_t       state, state_nxt;
  logic [PW-1:0]   wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0]   wr_nxt, cm_nxt, rd_nxt;
  logic [PW-1:0]   base;
  logic [LW-1:0]   len, len_nxt;
  logic            we;
  logic [AW-1:0]   waddr;
  logic            drop_nxt;
  logic            commit;
  logic            start;
  logic            avail;
  logic            load;
  logic            pop_eop;
  logic            out_first;

  // Write-side decode: decide what the incoming beat does to the open packet.
  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cm_nxt    = cm_ptr;
    len_nxt   = len;
    we        = 1'b0;
    waddr     = wr_ptr[AW-1:0];
    drop_nxt  = 1'b0;
    commit    = 1'b0;
    start     = 1'b0;
    base      = cm_ptr;
    if (in_valid) begin
      case (state)
        IDLE: start = in_sop;
        RECV: begin
          if (in_sop) begin
            drop_nxt = 1'b1;
            start    = 1'b1;
          end else if (((wr_ptr - rd_ptr) < PW'(DEPTH)) && (len < LW'(MAX_PKT))) begin
            we      = 1'b1;
            wr_nxt  = wr_ptr + 1'b1;
            len_nxt = len + 1'b1;
            if (in_eop) begin
              cm_nxt    = wr_ptr + 1'b1;
              commit    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            wr_nxt = cm_ptr;
            if (in_eop) begin
              drop_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (in_sop) begin
            drop_nxt = 1'b1;
            start    = 1'b1;
          end else if (in_eop) begin
            drop_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (start) begin
        waddr  = base[AW-1:0];
        wr_nxt = base;
        if ((base - rd_ptr) < PW'(DEPTH)) begin
          we      = 1'b1;
          wr_nxt  = base + 1'b1;
          len_nxt = LW'(1);
          if (in_eop) begin
            cm_nxt    = base + 1'b1;
            commit    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RECV;
          end
        end else if (in_eop) begin
          drop_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DISCARD;
        end
      end
    end
  end

  // Read-side decode: refill the output register whenever it is free or being taken.
  always_comb begin
    avail   = (cm_ptr != rd_ptr);
    load    = avail && (!out_valid || out_ready);
    rd_nxt  = load ? (rd_ptr + 1'b1) : rd_ptr;
    pop_eop = out_valid && out_ready && out_eop;
  end

  // Write FSM and write pointers; full reflects occupancy after this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      cm_ptr <= '0;
      len    <= '0;
      drop   <= 1'b0;
      full   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_nxt;
      cm_ptr <= cm_nxt;
      len    <= len_nxt;
      drop   <= drop_nxt;
      full   <= ((wr_nxt - rd_nxt) == PW'(DEPTH));
    end
  end

  // Beat storage: data plus its eop flag so the reader can frame packets.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {in_eop, in_data};
    end
  end

  // Output register: loads the next committed beat, holds while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_first <= 1'b1;
    end else if (load) begin
      rd_ptr    <= rd_ptr + 1'b1;
      out_valid <= 1'b1;
      out_data  <= mem[rd_ptr[AW-1:0]][DATA_W-1:0];
      out_eop   <= mem[rd_ptr[AW-1:0]][DATA_W];
      out_sop   <= out_first;
      out_first <= mem[rd_ptr[AW-1:0]][DATA_W];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Committed-packet counter: up on commit, down when a packet's last beat leaves.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_count <= '0;
    end else begin
      case ({commit, pop_eop})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_port_pkt_buffer.sv
// tb_port_pkt_buffer: scoreboard bench for port_pkt_buffer with a queue-based
// reference model and directed plus randomized packet traffic.
module tb_port_pkt_buffer;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 64;
  localparam int MAX_PKT = 32;
  localparam int AW      = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic [AW:0]       pkt_count;
  logic              drop;
  logic              full;

  port_pkt_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .MAX_PKT(MAX_PKT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .pkt_count(pkt_count),
    .drop     (drop),
    .full     (full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;
  int seq = 0;

  // Reference model state: open packet, committed-but-unread beats, expected output.
  logic [DATA_W:0]   pend[$];
  logic [DATA_W:0]   cq[$];
  logic [DATA_W+1:0] exp_q[$];
  bit discarding = 1'b0;
  bit m_ov = 1'b0;
  bit m_cur_eop = 1'b0;
  bit m_drop = 1'b0;
  bit m_full = 1'b0;
  int m_pkt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_sop   = s;
    in_eop   = e;
    in_data  = d;
    case (ready_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = (($urandom % 3) != 0);
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic sendPkt(input int len);
    for (int i = 0; i < len; i++) begin
      applyStimulus(1'b1, i == 0, i == len - 1, 8'(seq));
      seq++;
    end
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sop", 32'(out_sop), 32'd0);
    checkOutput("rst_out_eop", 32'(out_eop), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    reset = 1'b1;
  endtask

  // Reference model: advances one clock using queue arithmetic over packets.
  always @(posedge clk) begin : ref_model
    int cq_n;
    int occ;
    bit ld;
    bit dec;
    bit start;
    bit commit_now;
    logic [DATA_W:0] tmp;
    if (!reset) begin
      pend.delete();
      cq.delete();
      exp_q.delete();
      discarding = 1'b0;
      m_ov = 1'b0;
      m_cur_eop = 1'b0;
      m_drop = 1'b0;
      m_full = 1'b0;
      m_pkt = 0;
    end else begin
      cq_n = cq.size();
      occ  = cq_n + pend.size();
      dec  = m_ov && out_ready && m_cur_eop;
      ld   = (cq_n > 0) && (!m_ov || out_ready);
      if (ld) begin
        tmp = cq.pop_front();
        m_cur_eop = tmp[DATA_W];
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      m_drop = 1'b0;
      start = 1'b0;
      commit_now = 1'b0;
      if (in_valid) begin
        if (pend.size() > 0) begin
          if (in_sop) begin
            m_drop = 1'b1;
            pend.delete();
            start = 1'b1;
          end else if (occ < DEPTH && pend.size() < MAX_PKT) begin
            pend.push_back({in_eop, in_data});
            if (in_eop) commit_now = 1'b1;
          end else begin
            pend.delete();
            if (in_eop) m_drop = 1'b1;
            else discarding = 1'b1;
          end
        end else if (discarding) begin
          if (in_sop) begin
            m_drop = 1'b1;
            discarding = 1'b0;
            start = 1'b1;
          end else if (in_eop) begin
            m_drop = 1'b1;
            discarding = 1'b0;
          end
        end else if (in_sop) begin
          start = 1'b1;
        end
        if (start) begin
          if (cq_n < DEPTH) begin
            pend.push_back({in_eop, in_data});
            if (in_eop) commit_now = 1'b1;
          end else if (in_eop) begin
            m_drop = 1'b1;
          end else begin
            discarding = 1'b1;
          end
        end
      end
      if (commit_now) begin
        foreach (pend[i]) begin
          exp_q.push_back({i == 0, pend[i]});
          cq.push_back(pend[i]);
        end
        pend.delete();
      end
      if (commit_now && !dec) m_pkt++;
      else if (dec && !commit_now) m_pkt--;
      m_full = ((cq.size() + pend.size()) == DEPTH);
    end
  end

  // Monitor: compares status every cycle and each presented beat against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [DATA_W+1:0] e;
    checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
    checkOutput("drop", 32'(drop), 32'(m_drop));
    checkOutput("pkt_count", 32'(pkt_count), 32'(m_pkt));
    checkOutput("full", 32'(full), 32'(m_full));
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_beat: got data %0d, expected no beat at %0t", out_data, $time);
      end else begin
        e = exp_q[0];
        checkOutput("out_data", 32'(out_data), 32'(e[DATA_W-1:0]));
        checkOutput("out_eop", 32'(out_eop), 32'(e[DATA_W]));
        checkOutput("out_sop", 32'(out_sop), 32'(e[DATA_W+1]));
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1;
    pulseReset();
    pulseReset();

    // Single 4-beat packet with a ready consumer.
    $display("[TB] directed: 4-beat packet");
    out_ready = 1'b1;
    sendPkt(4);
    idleCycles(10);

    // Over-length packet followed by a short good one.
    $display("[TB] directed: over-length packet");
    sendPkt(40);
    idleCycles(3);
    sendPkt(2);
    idleCycles(10);

    // Fill the buffer with the consumer stalled, then drain.
    $display("[TB] directed: overflow");
    out_ready = 1'b0;
    sendPkt(30);
    sendPkt(30);
    sendPkt(10);
    idleCycles(5);
    checkOutput("held_pkts", 32'(pkt_count), 32'd2);
    out_ready = 1'b1;
    idleCycles(80);

    // Backpressure toggling every cycle.
    $display("[TB] directed: toggling ready");
    ready_mode = 1;
    sendPkt(5);
    idleCycles(20);
    ready_mode = 0;
    out_ready = 1'b1;

    // Start of packet arriving inside an open packet.
    $display("[TB] directed: sop mid-packet");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hB0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hB1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hB2);
    idleCycles(10);

    // Back-to-back packets that wrap the pointers several times.
    $display("[TB] directed: wrap-around");
    for (int p = 0; p < 20; p++) sendPkt(7);
    idleCycles(15);

    // Reset in the middle of a packet with committed data still queued.
    $display("[TB] directed: reset mid-packet");
    out_ready = 1'b0;
    sendPkt(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hC0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hC1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hC2);
    pulseReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hC3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC4);
    out_ready = 1'b1;
    idleCycles(10);

    // Randomized traffic: whole packets, stray beats and random backpressure.
    $display("[TB] random traffic");
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom % 10;
      ready_mode = (it % 40 < 8) ? 0 : 2;
      if (ready_mode == 0) out_ready = 1'b0;
      if (r < 6) begin
        sendPkt($urandom_range(1, 40));
        idleCycles($urandom_range(0, 2));
      end else begin
        for (int k = 0; k < 10; k++) begin
          applyStimulus(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 6) == 0, 8'($urandom));
        end
      end
    end

    ready_mode = 0;
    out_ready = 1'b1;
    idleCycles(200);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
